uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Next-generation debug-console UART transmitter.
- Adds a write FIFO so software/CPU bursts never stall on a per-byte handshake.
- Adds a runtime baud divisor, runtime parity mode (none/even/odd) and runtime 1 or 2 stop bits, so one block serves any clock/baud pair without resynthesis.
- Sits between the MMIO console register and the board UART TX pin.

Parameters:
DATA_WIDTH, 8, data bits per frame, LSB first; legal range 5..9.
FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
DIVISOR_WIDTH, 16, width of the runtime clocks-per-bit divisor.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
i_data  in  DATA_WIDTH  byte to enqueue
i_valid  in  1  enqueue request
o_ready  out  1  FIFO can accept; write occurs when i_valid && o_ready at posedge
i_baud_divisor  in  DIVISOR_WIDTH  clock cycles per bit (D); 0 treated as 1
i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 none (reserved)
i_two_stop_bits  in  1  1 = two stop bits
i_tx_enable  in  1  0 = do not start new frames
o_uart  out  1  serial line, idle high
o_busy  out  1  frame in progress or FIFO non-empty
o_fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
Interface fact: one clock, i_clk; reset i_rst is synchronous and active-high.

Reset values:
- o_uart=1, o_ready=0, o_busy=0, o_fifo_count=0, FSM=IDLE.
- o_ready is registered; it rises on the first cycle after i_rst deasserts.

Reset mid-frame:
- Frame is aborted and FIFO contents are discarded.
- o_uart is high from the cycle after i_rst is sampled high.

FIFO:
- o_ready = (count < FIFO_DEPTH), registered from next-state count.
- Simultaneous write and pop leaves count unchanged.
- Write while full cannot occur, because o_ready is low.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: FIFO non-empty && i_tx_enable. Pop occurs this cycle (cycle P).
- At pop, latch the shift register, D (as max(1, i_baud_divisor)), parity mode and stop count. Config changes mid-frame affect only later frames.
- o_uart is registered. START drives 0 from P+1 for exactly D cycles.
- DATA: DATA_WIDTH bits, LSB first, D cycles each.
- PARITY: present only when mode is 01 or 10.
  - Even: bit = XOR of data.
  - Odd: bit = ~XOR of data.
  - Lasts D cycles.
- STOP: 1 for D or 2*D cycles.
- End of STOP:
  - If FIFO non-empty && i_tx_enable: pop and go to START, so the next start bit begins with zero idle gap.
  - Otherwise go to IDLE.
- Frame length = (1 + DATA_WIDTH + p + s) * D cycles, where p ∈ {0,1} and s ∈ {1,2}.

Latency: a write accepted at cycle T into an empty FIFO with FSM idle and enabled produces o_uart=0 at T+2.

i_tx_enable:
- Deasserting it mid-frame finishes the current frame.
- No new pop occurs while it is low.
- Writes are still accepted.

Bit counter and divisor counter:
- Divisor counter counts down from D-1 to 0. Bit advance happens on 0.
- Bit counter is $clog2(DATA_WIDTH+1) bits wide. No underflow.

o_busy = (state != IDLE) || (count != 0), combinational.

Decomposition:
- Package uart_pkg holds:
  - uart_parity_e (PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_RSVD)
  - uart_tx_state_e
  - localparam DefaultDivisor (CLK_FREQ_HZ/BAUD_RATE helper function)
- Sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH) provides push/pop/count/full/empty with first-word-fall-through read.
- The top level contains only the FSM and shift datapath.

Test Plan:
- D=4, parity none, 1 stop, write 0xA5 -> o_uart low at T+2 for 4 cycles; bits 1,0,1,0,0,1,0,1 at 4 cycles each; high for 4; 40-cycle frame; o_busy falls after stop.
- D=3, even parity, write 0x07 -> parity bit 1 after data; odd parity with 0x07 -> parity bit 0; frame 33 cycles.
- Burst of 20 writes with D=2, valid held high -> o_ready drops when count=16; all 20 bytes emitted in order with zero gap between frames; count returns to 0.
- D=5, two stop bits, write 0x00 then 0xFF -> stop high for 10 cycles; second start bit immediately follows; i_baud_divisor=0 -> 1-cycle bits.
- i_tx_enable=0 with 3 queued -> o_uart stays high, count=3; enable -> frames start within 1 cycle; drop enable mid-frame -> current frame completes, next withheld.
- i_rst pulsed mid-data-bit -> o_uart=1 next cycle, count=0, o_ready=0 during reset, 1 the cycle after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the console UART transmitter.
//   uart_parity_e   : encoding of the runtime parity-mode input
//   uart_tx_state_e : transmitter FSM states
//   DefaultDivisor  : clocks-per-bit for the nominal board clock and baud rate
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'b00,
        PARITY_EVEN = 2'b01,
        PARITY_ODD  = 2'b10,
        PARITY_RSVD = 2'b11
    } uart_parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_e;

    // Rounded to the nearest whole clock so the bit-time error stays below half a clock.
    function automatic int unsigned baud_divisor(input int unsigned clk_freq_hz,
                                                 input int unsigned baud_rate);
        return (clk_freq_hz + baud_rate / 2) / baud_rate;
    endfunction

    localparam int unsigned ClkFreqHz      = 50_000_000;
    localparam int unsigned BaudRate       = 115_200;
    localparam int unsigned DefaultDivisor = baud_divisor(ClkFreqHz, BaudRate);

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// Synchronous FIFO with first-word-fall-through read.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_push, i_push_data: write request and data; accepted only while o_ready
//   o_ready            : registered "not full", low during reset
//   i_pop, o_pop_data  : pop request (ignored when empty) and head-of-queue data
//   o_count            : occupancy; o_full / o_empty decoded from it
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_push,
    input  logic [DATA_WIDTH-1:0]              i_push_data,
    output logic                               o_ready,
    input  logic                               i_pop,
    output logic [DATA_WIDTH-1:0]              o_pop_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
    output logic                               o_full,
    output logic                               o_empty
);

    localparam int AddrWidth  = $clog2(FIFO_DEPTH);
    localparam int CountWidth = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AddrWidth-1:0]  wr_ptr;
    logic [AddrWidth-1:0]  rd_ptr;
    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] count_d;
    logic                  do_push;
    logic                  do_pop;

    assign do_push    = i_push && o_ready;
    assign do_pop     = i_pop && !o_empty;
    assign o_empty    = (count_q == '0);
    assign o_full     = (count_q == CountWidth'(FIFO_DEPTH));
    assign o_count    = count_q;
    assign o_pop_data = mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CountWidth'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CountWidth'(1);
        end
    end

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            o_ready <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AddrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AddrWidth'(1);
            end
            count_q <= count_d;
            o_ready <= (count_d < CountWidth'(FIFO_DEPTH));
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Console UART transmitter with write FIFO and runtime line configuration.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_data, i_valid  : byte to enqueue, accepted when i_valid && o_ready
//   o_ready          : FIFO has room (registered)
//   i_baud_divisor   : clocks per bit, 0 behaves as 1
//   i_parity_mode    : 00 none, 01 even, 10 odd, 11 none
//   i_two_stop_bits  : 1 selects two stop bits
//   i_tx_enable      : gates the start of new frames only
//   o_uart           : serial line, idle high
//   o_busy           : frame in progress or FIFO non-empty
//   o_fifo_count     : FIFO occupancy
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high, waiting for a queued byte while enabled
// ST_START  | start bit (0) for D clocks
// ST_DATA   | DATA_WIDTH data bits, LSB first, D clocks each
// ST_PARITY | parity bit for D clocks (even/odd modes only)
// ST_STOP   | stop bit(s) high; chains straight into the next frame
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned DIVISOR_WIDTH = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [DATA_WIDTH-1:0]              i_data,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [DIVISOR_WIDTH-1:0]           i_baud_divisor,
    input  logic [1:0]                         i_parity_mode,
    input  logic                               i_two_stop_bits,
    input  logic                               i_tx_enable,
    output logic                               o_uart,
    output logic                               o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count
);

    localparam int BitCntWidth = $clog2(DATA_WIDTH + 1);
    localparam logic [BitCntWidth-1:0] LastBitLoad = BitCntWidth'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  fifo_pop;
    // Full is already expressed by o_ready; the flag exists for other FIFO users.
    logic                  fifo_full_unused;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (i_valid),
        .i_push_data (i_data),
        .o_ready     (o_ready),
        .i_pop       (fifo_pop),
        .o_pop_data  (fifo_rd_data),
        .o_count     (o_fifo_count),
        .o_full      (fifo_full_unused),
        .o_empty     (fifo_empty)
    );

    uart_tx_state_e              state_q, state_d;
    logic [DIVISOR_WIDTH-1:0]    div_q, div_d;
    logic [DIVISOR_WIDTH-1:0]    div_cnt_q, div_cnt_d;
    logic [BitCntWidth-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]       shift_q, shift_d;
    logic                        par_en_q, par_en_d;
    logic                        par_bit_q, par_bit_d;
    logic                        two_stop_q, two_stop_d;
    logic                        stop_extra_q, stop_extra_d;
    logic                        uart_q, uart_d;

    uart_parity_e                parity_mode;
    logic [DIVISOR_WIDTH-1:0]    eff_div;
    logic                        tick;
    logic                        load;

    assign parity_mode = uart_parity_e'(i_parity_mode);
    assign eff_div     = (i_baud_divisor == '0) ? DIVISOR_WIDTH'(1) : i_baud_divisor;
    assign tick        = (div_cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        two_stop_d   = two_stop_q;
        stop_extra_d = stop_extra_q;
        uart_d       = uart_q;
        load         = 1'b0;
        fifo_pop     = 1'b0;

        if (state_q != ST_IDLE) begin
            div_cnt_d = tick ? (div_q - DIVISOR_WIDTH'(1)) : (div_cnt_q - DIVISOR_WIDTH'(1));
        end

        case (state_q)
            ST_IDLE: begin
                uart_d = 1'b1;
                if (!fifo_empty && i_tx_enable) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    uart_d    = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = LastBitLoad;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q != '0) begin
                        uart_d    = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q - BitCntWidth'(1);
                    end else if (par_en_q) begin
                        state_d = ST_PARITY;
                        uart_d  = par_bit_q;
                    end else begin
                        state_d      = ST_STOP;
                        uart_d       = 1'b1;
                        stop_extra_d = two_stop_q;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d      = ST_STOP;
                    uart_d       = 1'b1;
                    stop_extra_d = two_stop_q;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_extra_q) begin
                        stop_extra_d = 1'b0;
                    end else if (!fifo_empty && i_tx_enable) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                uart_d  = 1'b1;
            end
        endcase

        // Line configuration is captured with the byte so mid-frame changes wait for the next frame.
        if (load) begin
            fifo_pop   = 1'b1;
            state_d    = ST_START;
            uart_d     = 1'b0;
            shift_d    = fifo_rd_data;
            div_d      = eff_div;
            div_cnt_d  = eff_div - DIVISOR_WIDTH'(1);
            par_en_d   = (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
            par_bit_d  = (^fifo_rd_data) ^ (parity_mode == PARITY_ODD);
            two_stop_d = i_two_stop_bits;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            div_q        <= DIVISOR_WIDTH'(1);
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            two_stop_q   <= 1'b0;
            stop_extra_q <= 1'b0;
            uart_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            two_stop_q   <= two_stop_d;
            stop_extra_q <= stop_extra_d;
            uart_q       <= uart_d;
        end
    end

    assign o_uart = uart_q;
    assign o_busy = (state_q != ST_IDLE) || (o_fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_baud_divisor;
    logic [1:0]  i_parity_mode;
    logic        i_two_stop_bits;
    logic        i_tx_enable;
    logic        o_uart;
    logic        o_busy;
    logic [4:0]  o_fifo_count;

    uart_tx_fifo dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_data          (i_data),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_baud_divisor  (i_baud_divisor),
        .i_parity_mode   (i_parity_mode),
        .i_two_stop_bits (i_two_stop_bits),
        .i_tx_enable     (i_tx_enable),
        .o_uart          (o_uart),
        .o_busy          (o_busy),
        .o_fifo_count    (o_fifo_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of bytes and the list of line levels still to be driven.
    logic [7:0] mq[$];
    bit         wave[$];
    bit         m_ready     = 1'b0;
    bit         model_valid = 1'b0;
    bit         m_push;

    function automatic void build_frame(input logic [7:0] b);
        int d;
        bit bits[$];
        d = (i_baud_divisor == 0) ? 1 : int'(i_baud_divisor);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (i_parity_mode == 2'b01) bits.push_back(^b);
        else if (i_parity_mode == 2'b10) bits.push_back(~^b);
        bits.push_back(1'b1);
        if (i_two_stop_bits) bits.push_back(1'b1);
        foreach (bits[j]) for (int r = 0; r < d; r++) wave.push_back(bits[j]);
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            mq.delete();
            wave.delete();
            m_ready = 1'b0;
        end else begin
            m_push = i_valid && m_ready;
            if (wave.size() > 0) void'(wave.pop_front());
            if (wave.size() == 0 && mq.size() > 0 && i_tx_enable) build_frame(mq.pop_front());
            if (m_push) mq.push_back(i_data);
            m_ready = (mq.size() < 16);
        end
        model_valid = 1'b1;
    end

    always @(negedge i_clk) begin
        if (model_valid) begin
            check("cyc_uart",  o_uart,       (wave.size() > 0) ? wave[0] : 1'b1);
            check("cyc_ready", o_ready,      m_ready);
            check("cyc_busy",  o_busy,       (wave.size() > 0) || (mq.size() > 0));
            check("cyc_count", o_fifo_count, mq.size());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Returns in the cycle after the accepting edge; leaves i_valid asserted.
    task automatic write_byte(input logic [7:0] b);
        int guard;
        guard   = 0;
        i_valid = 1'b1;
        i_data  = b;
        while (!o_ready && guard < 200) begin
            tick(1);
            guard++;
        end
        if (!o_ready) check("write_timeout", 0, 1);
        tick(1);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (o_busy && guard < 3000) begin
            tick(1);
            guard++;
        end
        if (o_busy) check("idle_timeout", 0, 1);
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    logic [9:0] frame_a5;
    logic [9:0] frame_55;
    bit         seen_full;

    initial begin
        frame_a5        = 10'b1_10100101_0;
        frame_55        = 10'b1_01010101_0;
        i_rst           = 1'b1;
        i_valid         = 1'b0;
        i_data          = 8'h00;
        i_baud_divisor  = 16'd4;
        i_parity_mode   = 2'b00;
        i_two_stop_bits = 1'b0;
        i_tx_enable     = 1'b1;

        tick(3);
        check("rst_uart",  o_uart, 1);
        check("rst_ready", o_ready, 0);
        check("rst_busy",  o_busy, 0);
        check("rst_count", o_fifo_count, 0);
        i_rst = 1'b0;
        check("rst_ready_release_cycle", o_ready, 0);
        tick(1);
        check("ready_after_release", o_ready, 1);

        // D=4, no parity, one stop, 0xA5
        write_byte(8'hA5);
        i_valid = 1'b0;
        check("a5_not_yet_started", o_uart, 1);
        tick(1);
        for (int k = 0; k < 10; k++) begin
            check("a5_bit", o_uart, frame_a5[k]);
            tick(3);
            if (k == 9) check("a5_busy_last_cycle", o_busy, 1);
            tick(1);
        end
        check("a5_busy_after_40", o_busy, 0);
        check("a5_line_idle", o_uart, 1);
        wait_idle();

        // D=3 even then odd parity, 0x07
        i_baud_divisor = 16'd3;
        i_parity_mode  = 2'b01;
        write_byte(8'h07);
        i_valid = 1'b0;
        tick(1);
        tick(24);
        check("even_data7", o_uart, 0);
        tick(3);
        check("even_parity", o_uart, 1);
        tick(5);
        check("even_busy_32", o_busy, 1);
        tick(1);
        check("even_busy_33", o_busy, 0);
        wait_idle();
        i_parity_mode = 2'b10;
        write_byte(8'h07);
        i_valid = 1'b0;
        tick(28);
        check("odd_parity", o_uart, 0);
        wait_idle();

        // D=2 burst of 20 with valid held
        i_baud_divisor = 16'd2;
        i_parity_mode  = 2'b00;
        seen_full      = 1'b0;
        i_valid        = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int guard;
            guard  = 0;
            i_data = 8'h30 + 8'(i);
            while (!o_ready && guard < 200) begin
                if (o_fifo_count == 5'd16) seen_full = 1'b1;
                tick(1);
                guard++;
            end
            tick(1);
        end
        i_valid = 1'b0;
        check("burst_hit_full", seen_full, 1);
        wait_idle();
        check("burst_count_drained", o_fifo_count, 0);

        // D=5, two stop bits, 0x00 then 0xFF back to back
        i_baud_divisor  = 16'd5;
        i_two_stop_bits = 1'b1;
        write_byte(8'h00);
        write_byte(8'hFF);
        i_valid = 1'b0;
        check("two_stop_start", o_uart, 0);
        tick(45);
        check("two_stop_first", o_uart, 1);
        tick(9);
        check("two_stop_last", o_uart, 1);
        tick(1);
        check("second_start_no_gap", o_uart, 0);
        tick(5);
        check("ff_bit0", o_uart, 1);
        wait_idle();

        // divisor 0 acts as 1
        i_baud_divisor  = 16'd0;
        i_two_stop_bits = 1'b0;
        write_byte(8'h55);
        i_valid = 1'b0;
        tick(1);
        for (int k = 0; k < 10; k++) begin
            check("div0_bit", o_uart, frame_55[k]);
            tick(1);
        end
        check("div0_busy_after_10", o_busy, 0);
        wait_idle();

        // enable gating
        i_baud_divisor = 16'd2;
        i_tx_enable    = 1'b0;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        i_valid = 1'b0;
        tick(3);
        check("dis_line_high", o_uart, 1);
        check("dis_count", o_fifo_count, 3);
        check("dis_busy", o_busy, 1);
        i_tx_enable = 1'b1;
        tick(1);
        check("en_start", o_uart, 0);
        check("en_count", o_fifo_count, 2);
        tick(5);
        i_tx_enable = 1'b0;
        tick(14);
        check("dis_mid_stop", o_uart, 1);
        tick(1);
        check("dis_withheld_line", o_uart, 1);
        check("dis_withheld_count", o_fifo_count, 2);
        tick(10);
        check("dis_still_withheld", o_fifo_count, 2);
        i_tx_enable = 1'b1;
        wait_idle();

        // reset during a data bit
        i_baud_divisor = 16'd4;
        write_byte(8'hA5);
        write_byte(8'h3C);
        i_valid = 1'b0;
        tick(9);
        check("pre_rst_bit1", o_uart, 0);
        i_rst = 1'b1;
        tick(1);
        check("mid_rst_uart", o_uart, 1);
        check("mid_rst_count", o_fifo_count, 0);
        check("mid_rst_ready", o_ready, 0);
        check("mid_rst_busy", o_busy, 0);
        tick(1);
        i_rst = 1'b0;
        check("mid_rst_ready_release", o_ready, 0);
        tick(1);
        check("mid_rst_ready_after", o_ready, 1);
        check("mid_rst_line_idle", o_uart, 1);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
